// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared conditioner states, colour codes and one-hot encoder
package simon_pkg;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_PRESS_DB   = 2'd1,
    S_HELD       = 2'd2,
    S_RELEASE_DB = 2'd3
  } cond_state_e;

  localparam logic [1:0] COL_0 = 2'd0;
  localparam logic [1:0] COL_1 = 2'd1;
  localparam logic [1:0] COL_2 = 2'd2;
  localparam logic [1:0] COL_3 = 2'd3;

  // True when exactly one button bit is set.
  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // One-hot button pattern to colour code; callers only pass one-hot values.
  function automatic logic [1:0] encode_onehot(input logic [3:0] v);
    logic [1:0] code;
    case (v)
      4'b0001: code = COL_0;
      4'b0010: code = COL_1;
      4'b0100: code = COL_2;
      4'b1000: code = COL_3;
      default: code = COL_0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// rtl/bit_synchronizer.sv - parameterised-width two-flop synchroniser
module bit_synchronizer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two flop stages; only the second stage is safe to use downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronise, debounce and chord-filter the colour buttons
module button_conditioner
  import simon_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] btn_in,
  output logic       colour_valid,
  output logic [1:0] colour_code,
  output logic       multi_err,
  output logic       busy
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       sync;
  cond_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cap_q, cap_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;

  bit_synchronizer #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (btn_in),
    .q_o   (sync)
  );

  // State, counter, captured pattern and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= COL_0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  // Next state: debounce press, emit one event, then wait out a debounced release.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        if (en && (sync != 4'd0)) begin
          cap_d   = sync;
          cnt_d   = '0;
          state_d = S_PRESS_DB;
        end
      end
      S_PRESS_DB: begin
        if (sync != cap_q) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (!en) begin
          // Abandoned press still has to be released before the next one counts.
          state_d = S_HELD;
        end else if (cnt_q == CNT_LAST) begin
          if (is_onehot(cap_q)) begin
            valid_d = 1'b1;
            code_d  = encode_onehot(cap_q);
          end else begin
            err_d = 1'b1;
          end
          state_d = S_HELD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HELD: begin
        if (sync == 4'd0) begin
          cnt_d   = '0;
          state_d = S_RELEASE_DB;
        end
      end
      S_RELEASE_DB: begin
        if (sync != 4'd0) begin
          state_d = S_HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign colour_valid = valid_q;
  assign multi_err    = err_q;
  assign colour_code  = code_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - self-checking bench for button_conditioner
module tb_button_conditioner;

  localparam int DB = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [3:0] btn_in = 4'd0;
  logic       colour_valid;
  logic [1:0] colour_code;
  logic       multi_err;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  button_conditioner #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .btn_in       (btn_in),
    .colour_valid (colour_valid),
    .colour_code  (colour_code),
    .multi_err    (multi_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: a press is a run of identical nonzero synchronised samples lasting
  // DB+1 edges while enabled; afterwards DB+1 consecutive zero samples re-arm.
  int         edge_cnt = 0;
  bit         m_started = 0;
  logic [3:0] m_s1, m_s2, m_pat;
  bit         m_latched, m_cand;
  int         m_len, m_zero;
  logic       m_valid, m_err;
  logic [1:0] m_code;

  always @(posedge clk) begin
    edge_cnt++;
    if (reset) begin
      m_started = 1;
      m_s1 = 0; m_s2 = 0; m_pat = 0;
      m_latched = 0; m_cand = 0; m_len = 0; m_zero = 0;
      m_valid = 0; m_err = 0; m_code = 0;
    end else begin
      m_valid = 0;
      m_err = 0;
      if (m_latched) begin
        if (m_s2 == 0) begin
          m_zero++;
          if (m_zero == DB + 1) begin
            m_latched = 0;
            m_zero = 0;
          end
        end else begin
          m_zero = 0;
        end
      end else if (m_cand) begin
        if (m_s2 != m_pat) begin
          m_cand = 0;
        end else if (!en) begin
          m_cand = 0;
          m_latched = 1;
          m_zero = 0;
        end else begin
          m_len++;
          if (m_len == DB) begin
            m_cand = 0;
            m_latched = 1;
            m_zero = 0;
            if ($countones(m_pat) == 1) begin
              m_valid = 1;
              for (int i = 0; i < 4; i++) if (m_pat[i]) m_code = 2'(i);
            end else begin
              m_err = 1;
            end
          end
        end
      end else if (en && m_s2 != 0) begin
        m_cand = 1;
        m_pat = m_s2;
        m_len = 0;
      end
      m_s2 = m_s1;
      m_s1 = btn_in;
    end
  end

  // Per-cycle comparison against the model plus pulse bookkeeping.
  int vcnt = 0, ecnt = 0, vedge = -1, eedge = -1, fall_edge = -1, busy_hi = 0;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    if (m_started) begin
      check("colour_valid", int'(colour_valid), int'(m_valid));
      check("multi_err", int'(multi_err), int'(m_err));
      check("colour_code", int'(colour_code), int'(m_code));
      check("busy", int'(busy), int'(m_latched || m_cand));
      if (colour_valid === 1'b1) begin vcnt++; vedge = edge_cnt; end
      if (multi_err === 1'b1) begin ecnt++; eedge = edge_cnt; end
      if (busy === 1'b1) busy_hi++;
      if (prev_busy && busy === 1'b0) fall_edge = edge_cnt;
      prev_busy = busy;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic clr();
    vcnt = 0; ecnt = 0; vedge = -1; eedge = -1; fall_edge = -1; busy_hi = 0;
  endtask

  int t, t2;

  initial begin
    tick(3);
    check("rst_valid", int'(colour_valid), 0);
    check("rst_err", int'(multi_err), 0);
    check("rst_code", int'(colour_code), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b0;
    en = 1'b1;
    tick(2);

    // clean press of colour 2
    clr(); btn_in = 4'b0100; t = edge_cnt; tick(30);
    check("clean_count", vcnt, 1);
    check("clean_edge", vedge, t + 11);
    check("clean_code", int'(colour_code), 2);
    check("clean_no_err", ecnt, 0);
    btn_in = 4'd0; t = edge_cnt; tick(20);
    check("clean_busy_fall", fall_edge, t + 11);

    // chord keeps the previous code
    clr(); btn_in = 4'b1010; t = edge_cnt; tick(20);
    check("chord_err_count", ecnt, 1);
    check("chord_err_edge", eedge, t + 11);
    check("chord_no_valid", vcnt, 0);
    check("chord_code_kept", int'(colour_code), 2);
    btn_in = 4'd0; tick(20);

    // bounce then stable press of colour 0
    clr();
    for (int i = 0; i < 3; i++) begin
      btn_in = 4'b0001; tick(3);
      btn_in = 4'b0000; tick(3);
    end
    check("bounce_no_pulse", vcnt, 0);
    btn_in = 4'b0001; t = edge_cnt; tick(15);
    check("bounce_count", vcnt, 1);
    check("bounce_edge", vedge, t + 11);
    check("bounce_code", int'(colour_code), 0);
    btn_in = 4'd0; tick(20);

    // long hold with a short glitch, then a real re-press
    clr(); btn_in = 4'b1000; tick(40);
    btn_in = 4'd0; tick(4);
    btn_in = 4'b1000; tick(56);
    check("hold_count", vcnt, 1);
    check("hold_code", int'(colour_code), 3);
    btn_in = 4'd0; tick(12);
    btn_in = 4'b1000; t = edge_cnt; tick(20);
    check("repress_count", vcnt, 2);
    check("repress_edge", vedge, t + 11);
    btn_in = 4'd0; tick(20);

    // enable gating
    clr(); en = 1'b0; btn_in = 4'b0010; tick(20);
    check("en_off_no_pulse", vcnt, 0);
    check("en_off_busy", busy_hi, 0);
    btn_in = 4'd0; tick(5);
    en = 1'b1; btn_in = 4'b0010; tick(5);
    en = 1'b0; tick(10);
    check("en_drop_no_pulse", vcnt, 0);
    check("en_drop_held", int'(busy), 1);
    btn_in = 4'd0; tick(15);
    check("en_drop_released", int'(busy), 0);
    en = 1'b1; btn_in = 4'b0010; t = edge_cnt; tick(20);
    check("en_repress_count", vcnt, 1);
    check("en_repress_edge", vedge, t + 11);
    check("en_repress_code", int'(colour_code), 1);
    btn_in = 4'd0; tick(20);

    // reset at counter 5 with the button still held
    clr(); btn_in = 4'b0100; tick(8);
    reset = 1'b1; tick(1);
    check("mid_rst_valid", int'(colour_valid), 0);
    check("mid_rst_code", int'(colour_code), 0);
    check("mid_rst_busy", int'(busy), 0);
    reset = 1'b0; t2 = edge_cnt; tick(20);
    check("mid_rst_count", vcnt, 1);
    check("mid_rst_edge", vedge, t2 + 11);
    btn_in = 4'd0; tick(20);

    // reset coinciding with the terminal count
    clr(); btn_in = 4'b0001; tick(10);
    reset = 1'b1; tick(1);
    reset = 1'b0;
    check("term_rst_no_pulse", vcnt, 0);
    t2 = edge_cnt; tick(20);
    check("term_rst_count", vcnt, 1);
    check("term_rst_edge", vedge, t2 + 11);
    check("term_rst_code", int'(colour_code), 0);
    btn_in = 4'd0; tick(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Conditions the four raw colour buttons ui_in[3:0] before the wait stage consumes them.
- Synchronises the buttons, debounces both press and release, and rejects multi-button chords.
- Emits exactly one registered colour event per physical press: a 1-cycle colour_valid pulse plus a 2-bit colour_code.
- Replaces the combinational any-button OR and decoder path feeding the wait stage's colour_in/colour_val.

Parameters:
- DEBOUNCE_CYCLES, 50000, cycles the synchronised pattern must hold stable to accept a press or release; legal range >= 2; simulation builds use 8.
- CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width; derived, not overridden.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- en  in  1  accept new presses (high while the wait stage is enabled)
- btn_in  in  4  raw buttons, asynchronous; bit i = colour i
- colour_valid  out  1  1-cycle pulse, one accepted single-button press
- colour_code  out  2  encoded colour of the last accepted press; held between pulses
- multi_err  out  1  1-cycle pulse, debounced chord (more than one bit set) rejected
- busy  out  1  high in any state other than S_IDLE

Behaviour:
- Reset is synchronous and active-high; the clock is clk.
- Reset values: colour_valid=0, colour_code=0, multi_err=0, busy=0, state=S_IDLE, counter=0, captured=0, both synchroniser stages=0.
- Synchroniser: 2 flops per bit. sync = second stage. The FSM uses only sync.
- FSM states: S_IDLE, S_PRESS_DB, S_HELD, S_RELEASE_DB.
- S_IDLE:
  - If en=1 and sync!=0: captured<=sync, counter<=0, go to S_PRESS_DB.
  - If en=0: stay in S_IDLE, ignore sync.
- S_PRESS_DB:
  - If sync!=captured (bounce or pattern change): go to S_IDLE, counter<=0, no pulse.
  - Else if en=0: go to S_HELD with no pulse. The press is abandoned but its release is still awaited, so it is never double-counted.
  - Else if counter==DEBOUNCE_CYCLES-1:
    - captured one-hot: colour_valid<=1, colour_code<=encode(captured).
    - otherwise: multi_err<=1, colour_code unchanged.
    - Either way, go to S_HELD.
  - Else counter<=counter+1.
- S_HELD: if sync==0, counter<=0 and go to S_RELEASE_DB. Any nonzero sync (including a changed pattern) keeps S_HELD.
- S_RELEASE_DB:
  - If sync!=0: go to S_HELD.
  - Else if counter==DEBOUNCE_CYCLES-1: go to S_IDLE.
  - Else counter<=counter+1.
- Encode: 0001->0, 0010->1, 0100->2, 1000->3.
- Pulses: colour_valid and multi_err are registered and high exactly one cycle; they are never both high.
- Latency: btn_in changes before edge E0 and stays stable. colour_valid is high in the cycle following edge E(DEBOUNCE_CYCLES+2).
  - Two edges are spent in the synchroniser.
  - One edge is the S_IDLE capture.
  - DEBOUNCE_CYCLES edges are spent counting.
- Counter never wraps. It is cleared on every state entry that uses it and saturates at the compare value.
- busy is combinational from state. busy=0 only in S_IDLE.
- Reset mid-operation (any state): everything returns to reset values on the next edge and no pulse is emitted. A button still held after reset is debounced as a fresh press.
- Simultaneous reset and a terminal count: reset wins, no pulse.
- Held button: a button held indefinitely produces exactly one colour_valid. A further event requires a debounced release followed by a new debounced press.

Decomposition:
- Shared package simon_pkg holds:
  - state encoding: S_IDLE=2'd0, S_PRESS_DB=2'd1, S_HELD=2'd2, S_RELEASE_DB=2'd3
  - colour code constants: COL_0..COL_3 = 2'd0..2'd3
  - the one-hot-to-code encode function, shared with the display path's colour_encoder
- One natural sub-module: bit_synchronizer. It is a parameterised-width 2-flop synchroniser with synchronous reset, instantiated once at width 4.

Test Plan (DEBOUNCE_CYCLES=8):
- Clean press: en=1, btn_in=0100 held 30 cycles then released -> one colour_valid pulse in the cycle after edge 10, with colour_code=2; multi_err never asserts; busy returns low 11 cycles after the release edge plus the synchroniser delay.
- Bounce: btn_in toggles 0001/0000 every 3 cycles for 20 cycles, then 0001 stable for 15 cycles -> no pulse during toggling; exactly one colour_valid with colour_code=0, emitted 11 cycles after the final stable edge.
- Chord: btn_in=1010 held 20 cycles -> one multi_err pulse after edge 10; no colour_valid; colour_code keeps its previous value.
- Hold and re-press: btn_in=1000 held 100 cycles -> exactly one pulse (code 3). A 4-cycle release glitch inside the hold -> no second pulse. A release of 12+ cycles followed by a re-press -> second pulse.
- Enable gating: en=0 with btn_in=0010 pressed -> no pulse and busy=0. en drops during S_PRESS_DB -> no pulse; FSM enters S_HELD; after the button is released and pressed again with en=1, exactly one pulse with code 1.
- Reset mid-debounce: reset asserted for 1 cycle at counter=5 -> all outputs 0 next cycle, no pulse. The button is still held, so colour_valid follows 11 cycles after reset deasserts.
